// File: rtl/flatten_pkg.sv
// Shared types and addressing helper for the multi-channel stream flattener.
package flatten_pkg;

  typedef enum logic {ORDER_CHAN = 1'b0, ORDER_PIX = 1'b1} order_e;
  typedef enum logic {S_IDLE, S_STREAM} state_e;

  // Channel-major storage offset of element (c,p); hw is the per-channel map size.
  function automatic int unsigned flat_addr(input int unsigned c,
                                            input int unsigned p,
                                            input int unsigned hw);
    return c * hw + p;
  endfunction

endpackage

// File: rtl/flatten_addr_gen.sv
// Nested (channel, pixel) counter pair plus stream position, stepping in either order.
module flatten_addr_gen
  import flatten_pkg::*;
#(
  parameter int C  = 4,
  parameter int H  = 13,
  parameter int W  = 13,
  localparam int HW = H * W,
  localparam int N  = C * HW,
  localparam int CW = (C > 1) ? $clog2(C) : 1,
  localparam int PW = (HW > 1) ? $clog2(HW) : 1,
  localparam int KW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_i,
  input  logic          advance_i,
  input  order_e        order_i,
  output logic [CW-1:0] c_nxt_o,
  output logic [PW-1:0] p_nxt_o,
  output logic [KW-1:0] k_o,
  output logic          last_o
);

  localparam logic [CW-1:0] C_MAX = CW'(C - 1);
  localparam logic [PW-1:0] P_MAX = PW'(HW - 1);
  localparam logic [KW-1:0] K_MAX = KW'(N - 1);

  logic [CW-1:0] c_q, c_d;
  logic [PW-1:0] p_q, p_d;
  logic [KW-1:0] k_q, k_d;

  assign last_o = (k_q == K_MAX);

  always_comb begin
    c_d = c_q;
    p_d = p_q;
    k_d = k_q;
    if (clear_i) begin
      c_d = '0;
      p_d = '0;
      k_d = '0;
    end else if (advance_i) begin
      k_d = last_o ? '0 : k_q + 1'b1;
      // Inner counter wraps into the outer one; the outer wraps at frame end.
      if (order_i == ORDER_CHAN) begin
        if (p_q == P_MAX) begin
          p_d = '0;
          c_d = (c_q == C_MAX) ? '0 : c_q + 1'b1;
        end else begin
          p_d = p_q + 1'b1;
        end
      end else begin
        if (c_q == C_MAX) begin
          c_d = '0;
          p_d = (p_q == P_MAX) ? '0 : p_q + 1'b1;
        end else begin
          c_d = c_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      c_q <= '0;
      p_q <= '0;
      k_q <= '0;
    end else begin
      c_q <= c_d;
      p_q <= p_d;
      k_q <= k_d;
    end
  end

  assign c_nxt_o = c_d;
  assign p_nxt_o = p_d;
  assign k_o     = k_q;

endmodule

// File: rtl/flattener_stream.sv
// Serialises a C x H x W feature map into a ready/valid element stream.
module flattener_stream
  import flatten_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int H      = 13,
  parameter int W      = 13,
  parameter int C      = 4,
  localparam int HW = H * W,
  localparam int N  = C * HW,
  localparam int CW = (C > 1) ? $clog2(C) : 1,
  localparam int PW = (HW > 1) ? $clog2(HW) : 1,
  localparam int KW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       order,
  input  logic                       abort,
  input  logic [0:N-1][DATA_W-1:0]   in_map,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic [KW-1:0]              out_index,
  output logic                       busy,
  output logic                       done
);

  state_e              state_q, state_d;
  order_e              order_q, order_d;
  logic                done_q, done_d;
  logic                valid_q;
  logic [DATA_W-1:0]   data_q;
  logic                clear, advance, load;
  logic                hs, last;
  logic [CW-1:0]       c_nxt;
  logic [PW-1:0]       p_nxt;
  logic [KW-1:0]       k;
  logic [KW-1:0]       rd_addr;

  flatten_addr_gen #(.C(C), .H(H), .W(W)) u_addr (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (clear),
    .advance_i (advance),
    .order_i   (order_q),
    .c_nxt_o   (c_nxt),
    .p_nxt_o   (p_nxt),
    .k_o       (k),
    .last_o    (last)
  );

  assign hs      = valid_q & out_ready;
  // Fetch from the counters' next value so out_data lines up with out_index.
  assign rd_addr = KW'(flat_addr(32'(c_nxt), 32'(p_nxt), HW));

  always_comb begin
    state_d = state_q;
    order_d = order_q;
    done_d  = 1'b0;
    clear   = 1'b0;
    advance = 1'b0;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_STREAM;
          order_d = order_e'(order);
          clear   = 1'b1;
          load    = 1'b1;
        end
      end
      S_STREAM: begin
        if (abort) begin
          state_d = S_IDLE;
          clear   = 1'b1;
        end else if (hs) begin
          advance = 1'b1;
          if (last) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            load = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      order_q <= ORDER_CHAN;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      order_q <= order_d;
      done_q  <= done_d;
      valid_q <= (state_d == S_STREAM);
      if (load) data_q <= in_map[rd_addr];
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_last  = valid_q & last;
  assign out_index = k;
  assign busy      = (state_q == S_STREAM);
  assign done      = done_q;

endmodule

// File: tb/tb_flattener_stream.sv
// Directed bench: small 2x2x2 map for ordering/handshake cases, default map for full-frame count.
module tb_flattener_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, abort;

  // small instance: C=2, H=W=2, N=8
  logic              s_start, s_order, s_ready;
  logic [0:7][15:0]  s_map;
  logic [15:0]       s_data;
  logic              s_valid, s_last, s_busy, s_done;
  logic [2:0]        s_index;

  // default instance: C=4, 13x13, N=676
  logic              b_start, b_order, b_ready;
  logic [0:675][15:0] b_map;
  logic [15:0]       b_data;
  logic              b_valid, b_last, b_busy, b_done;
  logic [9:0]        b_index;

  flattener_stream #(.DATA_W(16), .H(2), .W(2), .C(2)) dut_s (
    .clk(clk), .reset(reset), .start(s_start), .order(s_order), .abort(abort),
    .in_map(s_map), .out_data(s_data), .out_valid(s_valid), .out_ready(s_ready),
    .out_last(s_last), .out_index(s_index), .busy(s_busy), .done(s_done)
  );

  flattener_stream dut_b (
    .clk(clk), .reset(reset), .start(b_start), .order(b_order), .abort(1'b0),
    .in_map(b_map), .out_data(b_data), .out_valid(b_valid), .out_ready(b_ready),
    .out_last(b_last), .out_index(b_index), .busy(b_busy), .done(b_done)
  );

  int total = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic elem(input string tag, input int d, input int idx, input bit lst);
    chk({tag, "_valid"}, 32'(s_valid), 32'd1);
    chk({tag, "_data"},  32'(s_data),  32'(d));
    chk({tag, "_index"}, 32'(s_index), 32'(idx));
    chk({tag, "_last"},  32'(s_last),  32'(lst));
  endtask

  task automatic idle_chk(input string tag, input bit dn);
    chk({tag, "_valid"}, 32'(s_valid), 32'd0);
    chk({tag, "_busy"},  32'(s_busy),  32'd0);
    chk({tag, "_done"},  32'(s_done),  32'(dn));
  endtask

  int seq_pix [8] = '{10, 14, 11, 15, 12, 16, 13, 17};
  int cnt;
  int bdata_last;
  bit got_done;

  initial begin
    for (int i = 0; i < 8; i++) s_map[i] = 16'(10 + i);
    for (int i = 0; i < 676; i++) b_map[i] = 16'(i);
    reset = 1'b1; abort = 1'b0;
    s_start = 1'b0; s_order = 1'b0; s_ready = 1'b1;
    b_start = 1'b0; b_order = 1'b0; b_ready = 1'b1;
    step(); step();

    // reset values
    idle_chk("rst", 1'b0);
    chk("rst_last",  32'(s_last),  32'd0);
    chk("rst_index", 32'(s_index), 32'd0);
    chk("rst_data",  32'(s_data),  32'd0);
    reset = 1'b0;
    step();

    // channel-major frame
    s_start = 1'b1; s_order = 1'b0;
    step();
    s_start = 1'b0;
    chk("o0_busy", 32'(s_busy), 32'd1);
    for (int i = 0; i < 8; i++) begin
      elem($sformatf("o0_e%0d", i), 10 + i, i, i == 7);
      step();
    end
    idle_chk("o0_end", 1'b1);
    step();
    idle_chk("o0_post", 1'b0);

    // pixel-interleaved frame
    s_start = 1'b1; s_order = 1'b1;
    step();
    s_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      elem($sformatf("o1_e%0d", i), seq_pix[i], i, i == 7);
      step();
    end
    idle_chk("o1_end", 1'b1);

    // start during the done cycle: new channel-major frame next cycle
    s_start = 1'b1; s_order = 1'b0;
    step();
    s_start = 1'b0;
    elem("b2b_e0", 10, 0, 1'b0);
    step();
    elem("b2b_e1", 11, 1, 1'b0);
    step();
    // backpressure on element 12
    s_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      elem($sformatf("bp_hold%0d", i), 12, 2, 1'b0);
      step();
    end
    s_ready = 1'b1;
    // mid-frame start with toggled order is ignored
    s_start = 1'b1; s_order = 1'b1;
    for (int i = 2; i < 8; i++) begin
      elem($sformatf("bp_e%0d", i), 10 + i, i, i == 7);
      step();
      if (i == 4) s_start = 1'b0;
    end
    s_start = 1'b0;
    idle_chk("bp_end", 1'b1);
    step();

    // abort after the third handshake
    s_start = 1'b1; s_order = 1'b0;
    step();
    s_start = 1'b0;
    step(); step(); step();
    elem("ab_pre", 13, 3, 1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    idle_chk("ab_next", 1'b0);
    step();
    idle_chk("ab_nodone", 1'b0);
    // abort and start together in IDLE
    abort = 1'b1; s_start = 1'b1;
    step();
    abort = 1'b0; s_start = 1'b0;
    idle_chk("ab_start", 1'b0);
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    elem("ab_restart", 10, 0, 1'b0);

    // reset mid-frame under backpressure
    step();
    s_ready = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0; s_ready = 1'b1;
    idle_chk("mrst", 1'b0);
    chk("mrst_data",  32'(s_data),  32'd0);
    chk("mrst_index", 32'(s_index), 32'd0);
    chk("mrst_last",  32'(s_last),  32'd0);

    // full default-size frame, channel-major
    b_start = 1'b1; b_order = 1'b0;
    step();
    b_start = 1'b0;
    cnt = 0; bdata_last = -1; got_done = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (b_valid && b_ready) begin
        cnt++;
        if (b_last) bdata_last = int'(b_data);
      end
      step();
      if (b_done) begin
        got_done = 1'b1;
        break;
      end
    end
    chk("big_done", 32'(got_done), 32'd1);
    chk("big_count", 32'(cnt), 32'd676);
    chk("big_lastdata", 32'(bdata_last), 32'd675);

    // default size, pixel-interleaved: k=1 is (c=1,p=0) at storage 169
    b_start = 1'b1; b_order = 1'b1;
    step();
    b_start = 1'b0;
    chk("bigpix_d0", 32'(b_data), 32'd0);
    step();
    chk("bigpix_d1", 32'(b_data), 32'd169);
    chk("bigpix_i1", 32'(b_index), 32'd1);
    step();
    chk("bigpix_d2", 32'(b_data), 32'd338);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/flattener_stream.md
# flattener_stream

Parametrised, multi-channel successor to the single-map flattener. It serialises a C-channel H×W pooled feature map into a one-element-per-cycle stream for the fully-connected stage. It adds a ready/valid handshake with backpressure, a run-time choice of output ordering, a last-element flag, an element index, and abort. It sits between the pooling array and the FC layer input.

## Interface
- `DATA_W`, 16, element width (signed two's complement)
- `H`, 13, map height
- `W`, 13, map width
- `C`, 4, channel count; total elements `N = C*H*W`
- `clk` in 1, rising-edge clock
- `reset` in 1, synchronous, active-high
- `start` in 1, begin a frame; honoured only in IDLE
- `order` in 1, sampled with `start`:
  - 0 = channel-major (out index `k = c*H*W + p`)
  - 1 = pixel-interleaved (`k = p*C + c`)
- `abort` in 1, terminate the current frame
- `in_map` in `DATA_W` × `[0:N-1]`, channel-major storage; element (c,p) is at `c*H*W + p`, with `p = row*W + col`
- `out_data` out `DATA_W`, current element
- `out_valid` out 1, `out_data` is valid
- `out_ready` in 1, consumer accepts
- `out_last` out 1, current element is the final one (`k = N-1`)
- `out_index` out `$clog2(N)`, stream position `k` of the current element
- `busy` out 1, high in STREAM
- `done` out 1, one-cycle pulse after the last handshake

## Operation
- FSM states:
  - IDLE: `out_valid=0`. `start=1` latches `order`, clears the counters `c` and `p`, goes to STREAM.
  - STREAM: presents the element at the current (c,p). Handshake = `out_valid & out_ready`.
  - On handshake, counters advance:
    - order 0: `p` increments; on `p=H*W-1`, `p` wraps to 0 and `c` increments.
    - order 1: `c` increments; on `c=C-1`, `c` wraps to 0 and `p` increments.
  - Handshake on `out_last` goes to IDLE and pulses `done`.
- `out_index` counts 0..N-1 in stream order, independent of `order`.
- `out_data` is registered from `in_map[c*H*W+p]`. The addressing is internal; no arithmetic is performed on the data.
- `in_map` must be stable from `start` until `done` or abort. The block does not snapshot it.
- Backpressure: while `out_valid & !out_ready`, `out_data`, `out_last` and `out_index` hold stable; counters do not move.
- `start` while busy: ignored, and `order` is not re-latched.
- `abort` in STREAM: next cycle IDLE, `out_valid=0`, no `done`. `abort` in IDLE: no effect. `abort` and `start` together in IDLE: abort wins, block stays IDLE.
- `reset` mid-frame: identical to abort, plus `order` cleared to 0.

## Timing
- Reset values:
  - `out_valid=0`, `out_last=0`, `done=0`, `busy=0`
  - `out_index=0`, `out_data=0`
  - state IDLE, counters 0
- `start` sampled high at edge t: at t+1 `busy=1`, `out_valid=1`, `out_index=0`, and `out_data` = first element.
- Throughput is 1 element/cycle with `out_ready` held high, so a frame of N elements ends with its last handshake at edge t+N.
- Last handshake at edge e: at e+1 `done=1`, `busy=0`, `out_valid=0`. `done` falls at e+2.
- `start` asserted during the `done` cycle is accepted, which allows back-to-back frames with a 1-cycle bubble.
- `out_valid` never drops without a handshake, except on abort or reset.

## Structure
- Package `flatten_pkg` holds:
  - `typedef enum logic {ORDER_CHAN=0, ORDER_PIX=1} order_e`
  - `typedef enum logic {S_IDLE, S_STREAM} state_e`
  - the function `flat_addr(c, p)`
- Sub-module `flatten_addr_gen`: the nested (c,p) counter pair, with wrap logic for both orders, `advance`/`clear` inputs, and `last` and `k` outputs.
- Top level: FSM, output register, handshake logic.

## Test plan
- C=2, H=W=2, order 0, `in_map`=10..17, `out_ready`=1 → `out_data` 10,11,12,13,14,15,16,17; `out_last` only on 17; `done` one cycle later.
- Same frame, order 1 → 10,14,11,15,12,16,13,17; `out_index` 0..7.
- Backpressure: `out_ready` low for 3 cycles while element 12 is valid → 12 held 3 cycles with `out_index=2`; no skip or duplicate after release.
- `abort` after the 3rd handshake → next cycle `out_valid=0`, `busy=0`, no `done`. A fresh `start` then restarts at element 10.
- `start` repeated mid-frame with order toggled → ignored; ordering unchanged. `start` in the `done` cycle → new frame begins the next cycle.
- `reset` held during STREAM with `out_ready=0` → all outputs at reset values on the next edge; default C=4, 13×13 frame yields exactly 676 handshakes.
